// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: instruction sequencing, datapath strobes,
// immediate-extension select and a req/ack memory watchdog.
module multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] ext_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC += 4 on ack
    // DECODE   | decode opcode, precompute branch target
    // MEMADR   | compute load/store address
    // MEMRD    | data read, wait for ack
    // MEMWB    | write MDR to rt
    // MEMWR    | data write, wait for ack
    // EXEC_R   | R-type ALU operation
    // ALUWB    | write ALUOut to rd
    // EXEC_I   | I-type ALU operation
    // IWB      | write ALUOut to rt
    // BRANCH   | compare, conditionally load PC
    // JUMP     | load jump target into PC
    // TRAP     | flag unsupported opcode, refetch
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC_R = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_EXEC_I = 4'd8;
    localparam logic [3:0] S_IWB    = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam bit             WD_EN   = (WAIT_LIMIT != 0);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WAIT_LIMIT);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_state;
    logic             wd_hit;

    // funct is consumed by the ALU control block, not by this FSM
    logic unused_funct;
    assign unused_funct = ^funct;

    assign req_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign wd_hit    = WD_EN && req_state && !mem_ack && (cnt_q == LIMIT_C);

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        pc_src      = 2'b00;
        ext_op      = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = wd_hit;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ack;
                pc_write  = mem_ack;
                if (mem_ack) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:                                    state_d = S_EXEC_R;
                    OP_LW, OP_SW:                                state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:                              state_d = S_BRANCH;
                    OP_J:                                        state_d = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:   state_d = S_EXEC_I;
                    default:                                     state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ack) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ack;
                if (mem_ack) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                state_d   = S_IWB;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_write   = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (state_q != S_FETCH) begin
            case (opcode)
                OP_ANDI, OP_ORI: ext_op = 2'b01;
                OP_LUI:          ext_op = 2'b10;
                default:         ext_op = 2'b00;
            endcase
        end

        // abandoned request: no completion, refetch from the unchanged PC
        if (wd_hit) state_d = S_FETCH;

        // reset holds FETCH, but the memory must not see a request while rstb is low
        if (!rstb) begin
            mem_req     = 1'b0;
            mem_write   = 1'b0;
            iord        = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            alu_op      = 2'b00;
            pc_src      = 2'b00;
            ext_op      = 2'b00;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
            mem_timeout = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (wd_hit || mem_ack ||
            ((state_d != state_q) &&
             ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR)))) begin
            cnt_d = '0;
        end else if (WD_EN && req_state) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every output checked as one packed vector per cycle
// against hand-computed values, WAIT_LIMIT reduced to 4 to exercise the watchdog.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_write, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
    logic       alu_src_a, instr_done, illegal_op, mem_timeout;
    logic [1:0] alu_src_b, alu_op, pc_src, ext_op;

    int checks = 0;
    int failures = 0;

    multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(5)) dut (
        .clk(clk), .rstb(rstb), .opcode(opcode), .funct(funct), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .ext_op(ext_op), .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {mem_req, mem_write, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, alu_op, pc_src, ext_op, instr_done, illegal_op, mem_timeout};

    function automatic logic [19:0] v(input logic req, wr, io, irw, pcw, rw, rdst, m2r, asa,
                                      input logic [1:0] asb, aop, psrc, ext,
                                      input logic done, ill, to);
        return {req, wr, io, irw, pcw, rw, rdst, m2r, asa, asb, aop, psrc, ext, done, ill, to};
    endfunction

    logic [19:0] F0, FA, FTO, MADR, MRD, MWB, MWR, MWR_DONE, MWR_TO, EXR, ALUWB, JMP, TRAP;

    task automatic chk(input string tag, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    // check current cycle's outputs, then advance to just after the next rising edge
    task automatic cyc(input string tag, input logic [19:0] exp);
        #1;
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [5:0] op, input logic [1:0] ext);
        opcode  = op;
        mem_ack = 1'b1;
        cyc("fetch_ack", FA);
        mem_ack = 1'b0;
        cyc("decode", v(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,ext,0,0,0));
    endtask

    initial begin
        F0       = v(1,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,0,0,0);
        FA       = v(1,0,0,1,1,0,0,0,0,2'b01,2'b00,2'b00,2'b00,0,0,0);
        FTO      = v(1,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,0,0,1);
        MADR     = v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,0,0,0);
        MRD      = v(1,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
        MWB      = v(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,1,0,0);
        MWR      = v(1,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
        MWR_DONE = v(1,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0,0);
        MWR_TO   = v(1,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,1);
        EXR      = v(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,2'b00,0,0,0);
        ALUWB    = v(0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,1,0,0);
        JMP      = v(0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b10,2'b00,1,0,0);
        TRAP     = v(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,0);

        #2;
        chk("reset_outputs", 20'h0);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        cyc("fetch_after_reset", F0);

        // async reset in the middle of a FETCH wait
        rstb = 1'b0;
        #1;
        chk("reset_mid_fetch", 20'h0);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        cyc("fetch_after_rerelease", F0);

        // lw with three wait cycles on both memory accesses
        opcode = 6'b100011;
        cyc("lw_fetch_w1", F0);
        cyc("lw_fetch_w2", F0);
        fetch_decode(6'b100011, 2'b00);
        cyc("lw_memadr", MADR);
        cyc("lw_memrd_w0", MRD);
        cyc("lw_memrd_w1", MRD);
        cyc("lw_memrd_w2", MRD);
        mem_ack = 1'b1;
        cyc("lw_memrd_ack", MRD);
        mem_ack = 1'b0;
        cyc("lw_memwb", MWB);
        cyc("lw_back_fetch", F0);

        // ori / lui / addi immediate extension
        fetch_decode(6'b001101, 2'b01);
        cyc("ori_exec_i", v(0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,2'b01,0,0,0));
        cyc("ori_iwb", v(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b01,1,0,0));
        fetch_decode(6'b001111, 2'b10);
        cyc("lui_exec_i", v(0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,2'b10,0,0,0));
        cyc("lui_iwb", v(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b10,1,0,0));
        fetch_decode(6'b001000, 2'b00);
        cyc("addi_exec_i", v(0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,2'b00,0,0,0));
        cyc("addi_iwb", v(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0,0));

        // branches
        zero = 1'b1;
        fetch_decode(6'b000100, 2'b00);
        cyc("beq_taken", v(0,0,0,0,1,0,0,0,1,2'b00,2'b01,2'b01,2'b00,1,0,0));
        fetch_decode(6'b000101, 2'b00);
        cyc("bne_not_taken", v(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,2'b00,1,0,0));
        zero = 1'b0;
        fetch_decode(6'b000101, 2'b00);
        cyc("bne_taken", v(0,0,0,0,1,0,0,0,1,2'b00,2'b01,2'b01,2'b00,1,0,0));

        // jump, then R-type with a stray ack during DECODE (no request outstanding)
        fetch_decode(6'b000010, 2'b00);
        cyc("jump", JMP);
        opcode  = 6'b000000;
        mem_ack = 1'b1;
        cyc("r_fetch_ack", FA);
        cyc("r_decode_stray_ack", v(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,2'b00,0,0,0));
        mem_ack = 1'b0;
        cyc("r_exec", EXR);
        cyc("r_aluwb", ALUWB);

        // sw never acked: four wait cycles, then timeout pulse, back to FETCH
        fetch_decode(6'b101011, 2'b00);
        cyc("sw_memadr", MADR);
        cyc("sw_wait0", MWR);
        cyc("sw_wait1", MWR);
        cyc("sw_wait2", MWR);
        cyc("sw_wait3", MWR);
        cyc("sw_timeout", MWR_TO);

        // FETCH with no ack also times out and stays in FETCH
        cyc("fetch_wait0", F0);
        cyc("fetch_wait1", F0);
        cyc("fetch_wait2", F0);
        cyc("fetch_wait3", F0);
        cyc("fetch_timeout", FTO);
        cyc("fetch_refetch", F0);

        // sw acked exactly at the limit: ack wins, instruction retires
        fetch_decode(6'b101011, 2'b00);
        cyc("sw2_memadr", MADR);
        cyc("sw2_wait0", MWR);
        cyc("sw2_wait1", MWR);
        cyc("sw2_wait2", MWR);
        cyc("sw2_wait3", MWR);
        mem_ack = 1'b1;
        cyc("sw2_ack_at_limit", MWR_DONE);
        mem_ack = 1'b0;
        cyc("sw2_back_fetch", F0);

        // unsupported opcode
        fetch_decode(6'b111111, 2'b00);
        cyc("trap", TRAP);
        cyc("trap_back_fetch", F0);

        // reset while a data read is pending
        fetch_decode(6'b100011, 2'b00);
        cyc("lw2_memadr", MADR);
        #1;
        chk("lw2_memrd", MRD);
        rstb = 1'b0;
        #1;
        chk("reset_mid_memrd", 20'h0);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        cyc("fetch_after_memrd_reset", F0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
